// File: rtl/issue_scheduler.sv
// Reservation-station issue scheduler: buffers renamed instructions, snoops wakeups, issues oldest ready entry.
// Optional ISSUE_WAKEUP_BYPASS_EN lets a same-cycle wakeup count toward eligibility.
module issue_scheduler #(
    parameter int ENTRIES             = 8,
    parameter int REG_FILE_ADDR_WIDTH = 7,
    parameter int ROB_ADDR_WIDTH      = 5,
    parameter int PAYLOAD_WIDTH       = 32
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic                           flush,
    input  logic                           dispatch_valid,
    output logic                           dispatch_ready,
    input  logic [ROB_ADDR_WIDTH-1:0]      dispatch_rob_idx,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rd,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rs1,
    input  logic                           dispatch_rs1_ready,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] dispatch_rs2,
    input  logic                           dispatch_rs2_ready,
    input  logic [PAYLOAD_WIDTH-1:0]       dispatch_payload,
    input  logic                           wakeup_valid,
    input  logic [REG_FILE_ADDR_WIDTH-1:0] wakeup_tag,
    output logic                           issue_valid,
    input  logic                           issue_ready,
    output logic [ROB_ADDR_WIDTH-1:0]      issue_rob_idx,
    output logic [REG_FILE_ADDR_WIDTH-1:0] issue_rd,
    output logic [REG_FILE_ADDR_WIDTH-1:0] issue_rs1,
    output logic [REG_FILE_ADDR_WIDTH-1:0] issue_rs2,
    output logic [PAYLOAD_WIDTH-1:0]       issue_payload,
    output logic [$clog2(ENTRIES):0]       occupancy,
    output logic                           empty,
    output logic                           full
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int OCC_W = IDX_W + 1;

    logic [ENTRIES-1:0]             ent_valid;
    logic [ENTRIES-1:0]             ent_rdy1;
    logic [ENTRIES-1:0]             ent_rdy2;
    logic [ROB_ADDR_WIDTH-1:0]      ent_rob [ENTRIES];
    logic [REG_FILE_ADDR_WIDTH-1:0] ent_rd  [ENTRIES];
    logic [REG_FILE_ADDR_WIDTH-1:0] ent_rs1 [ENTRIES];
    logic [REG_FILE_ADDR_WIDTH-1:0] ent_rs2 [ENTRIES];
    logic [PAYLOAD_WIDTH-1:0]       ent_pay [ENTRIES];
    logic [7:0]                     ent_age [ENTRIES];
    logic [OCC_W-1:0]               count;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic [ENTRIES-1:0] eligible;
    logic             pick_found;
    logic [IDX_W-1:0] pick_idx;
    logic [7:0]       pick_age;
    logic             disp_fire;
    logic             issue_fire;
    logic             disp_rdy1;
    logic             disp_rdy2;

    assign full           = (count == OCC_W'(ENTRIES));
    assign empty          = (count == '0);
    assign occupancy      = count;
    assign dispatch_ready = !full;
    assign disp_fire      = dispatch_valid && !full;
    assign issue_fire     = pick_found && issue_ready;
    assign disp_rdy1      = dispatch_rs1_ready || (wakeup_valid && (wakeup_tag == dispatch_rs1));
    assign disp_rdy2      = dispatch_rs2_ready || (wakeup_valid && (wakeup_tag == dispatch_rs2));

    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (!ent_valid[i] && !free_found) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        eligible = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
`ifdef ISSUE_WAKEUP_BYPASS_EN
            eligible[i] = ent_valid[i]
                && (ent_rdy1[i] || (wakeup_valid && (wakeup_tag == ent_rs1[i])))
                && (ent_rdy2[i] || (wakeup_valid && (wakeup_tag == ent_rs2[i])));
`else
            eligible[i] = ent_valid[i] && ent_rdy1[i] && ent_rdy2[i];
`endif
        end
    end

    // Strict '>' keeps the lowest index on equal ages; ages shift uniformly, so a stalled pick stays put
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        pick_age   = '0;
        for (int unsigned i = 0; i < ENTRIES; i++) begin
            if (eligible[i] && (!pick_found || (ent_age[i] > pick_age))) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(i);
                pick_age   = ent_age[i];
            end
        end
    end

    assign issue_valid   = pick_found;
    assign issue_rob_idx = pick_found ? ent_rob[pick_idx] : '0;
    assign issue_rd      = pick_found ? ent_rd[pick_idx]  : '0;
    assign issue_rs1     = pick_found ? ent_rs1[pick_idx] : '0;
    assign issue_rs2     = pick_found ? ent_rs2[pick_idx] : '0;
    assign issue_payload = pick_found ? ent_pay[pick_idx] : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            ent_valid <= '0;
            ent_rdy1  <= '0;
            ent_rdy2  <= '0;
            count     <= '0;
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                ent_age[i] <= '0;
            end
        end else if (flush) begin
            ent_valid <= '0;
            count     <= '0;
        end else begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                if (wakeup_valid && ent_valid[i] && (ent_rs1[i] == wakeup_tag)) begin
                    ent_rdy1[i] <= 1'b1;
                end
                if (wakeup_valid && ent_valid[i] && (ent_rs2[i] == wakeup_tag)) begin
                    ent_rdy2[i] <= 1'b1;
                end
                if (disp_fire && ent_valid[i] && (ent_age[i] != 8'hFF)) begin
                    ent_age[i] <= ent_age[i] + 8'd1;
                end
            end
            if (issue_fire) begin
                ent_valid[pick_idx] <= 1'b0;
            end
            if (disp_fire) begin
                ent_valid[free_idx] <= 1'b1;
                ent_rob[free_idx]   <= dispatch_rob_idx;
                ent_rd[free_idx]    <= dispatch_rd;
                ent_rs1[free_idx]   <= dispatch_rs1;
                ent_rs2[free_idx]   <= dispatch_rs2;
                ent_pay[free_idx]   <= dispatch_payload;
                ent_rdy1[free_idx]  <= disp_rdy1;
                ent_rdy2[free_idx]  <= disp_rdy2;
                ent_age[free_idx]   <= '0;
            end
            if (disp_fire && !issue_fire) begin
                count <= count + OCC_W'(1);
            end else if (!disp_fire && issue_fire) begin
                count <= count - OCC_W'(1);
            end
        end
    end
endmodule

// File: tb/tb_issue_scheduler.sv
// Scoreboard bench for issue_scheduler: expected issues queued at dispatch, popped by a handshake monitor.
module tb_issue_scheduler;
    logic        clock = 1'b0;
    logic        reset, flush;
    logic        dispatch_valid, dispatch_ready;
    logic [4:0]  dispatch_rob_idx;
    logic [6:0]  dispatch_rd, dispatch_rs1, dispatch_rs2;
    logic        dispatch_rs1_ready, dispatch_rs2_ready;
    logic [31:0] dispatch_payload;
    logic        wakeup_valid;
    logic [6:0]  wakeup_tag;
    logic        issue_valid, issue_ready;
    logic [4:0]  issue_rob_idx;
    logic [6:0]  issue_rd, issue_rs1, issue_rs2;
    logic [31:0] issue_payload;
    logic [3:0]  occupancy;
    logic        empty, full;

    typedef struct {
        logic [4:0]  rob;
        logic [6:0]  rd;
        logic [6:0]  rs1;
        logic [6:0]  rs2;
        logic [31:0] pay;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    issue_scheduler #(.ENTRIES(8), .REG_FILE_ADDR_WIDTH(7), .ROB_ADDR_WIDTH(5), .PAYLOAD_WIDTH(32)) dut (
        .clock(clock), .reset(reset), .flush(flush),
        .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
        .dispatch_rob_idx(dispatch_rob_idx), .dispatch_rd(dispatch_rd),
        .dispatch_rs1(dispatch_rs1), .dispatch_rs1_ready(dispatch_rs1_ready),
        .dispatch_rs2(dispatch_rs2), .dispatch_rs2_ready(dispatch_rs2_ready),
        .dispatch_payload(dispatch_payload),
        .wakeup_valid(wakeup_valid), .wakeup_tag(wakeup_tag),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_rob_idx(issue_rob_idx), .issue_rd(issue_rd),
        .issue_rs1(issue_rs1), .issue_rs2(issue_rs2), .issue_payload(issue_payload),
        .occupancy(occupancy), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    // Handshake completes at the next posedge; inputs only change just after posedges
    always @(negedge clock) begin
        if (!reset && !flush && issue_valid && issue_ready) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL issue_unexpected: got rob %0d rd %0d, required no issue", issue_rob_idx, issue_rd);
            end else begin
                exp_t e;
                e = q.pop_front();
                if (issue_rob_idx !== e.rob || issue_rd !== e.rd || issue_rs1 !== e.rs1 ||
                    issue_rs2 !== e.rs2 || issue_payload !== e.pay) begin
                    errors++;
                    $display("FAIL issue_fields: got rob %0d rd %0d rs1 %0d rs2 %0d pay %h, required rob %0d rd %0d rs1 %0d rs2 %0d pay %h",
                             issue_rob_idx, issue_rd, issue_rs1, issue_rs2, issue_payload,
                             e.rob, e.rd, e.rs1, e.rs2, e.pay);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, act, req);
        end
    endtask

    task automatic expect_issue(input logic [4:0] rob, input logic [6:0] rd, input logic [6:0] rs1,
                                input logic [6:0] rs2, input logic [31:0] pay);
        exp_t e;
        e.rob = rob; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2; e.pay = pay;
        q.push_back(e);
    endtask

    task automatic dispatch(input logic [4:0] rob, input logic [6:0] rd, input logic [6:0] rs1, input logic r1,
                            input logic [6:0] rs2, input logic r2, input logic [31:0] pay);
        dispatch_rob_idx   = rob;
        dispatch_rd        = rd;
        dispatch_rs1       = rs1;
        dispatch_rs1_ready = r1;
        dispatch_rs2       = rs2;
        dispatch_rs2_ready = r2;
        dispatch_payload   = pay;
        dispatch_valid     = 1'b1;
        tick();
        dispatch_valid     = 1'b0;
    endtask

    initial begin
        reset = 1'b1; flush = 1'b0; dispatch_valid = 1'b0;
        dispatch_rob_idx = '0; dispatch_rd = '0; dispatch_rs1 = '0; dispatch_rs2 = '0;
        dispatch_rs1_ready = 1'b0; dispatch_rs2_ready = 1'b0; dispatch_payload = '0;
        wakeup_valid = 1'b0; wakeup_tag = '0; issue_ready = 1'b0;
        tick(); tick();
        reset = 1'b0;
        check("rst_issue_valid", issue_valid, 0);
        check("rst_dispatch_ready", dispatch_ready, 1);
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_occupancy", occupancy, 0);
        check("rst_issue_rob", issue_rob_idx, 0);

        // single ready entry: visible the cycle after dispatch
        issue_ready = 1'b1;
        expect_issue(3, 40, 10, 11, 32'h1111_0003);
        dispatch(3, 40, 10, 1, 11, 1, 32'h1111_0003);
        check("lat_issue_valid", issue_valid, 1);
        check("lat_issue_rob", issue_rob_idx, 3);
        check("lat_issue_rd", issue_rd, 40);
        tick();
        check("lat_empty_after", empty, 1);

        // A waits on tag 20, younger B issues first
        expect_issue(5, 41, 21, 22, 32'hBBBB_0005);
        expect_issue(4, 42, 20, 23, 32'hAAAA_0004);
        dispatch(4, 42, 20, 0, 23, 1, 32'hAAAA_0004);
        check("blk_a_not_valid", issue_valid, 0);
        dispatch(5, 41, 21, 1, 22, 1, 32'hBBBB_0005);
        check("blk_b_rob", issue_rob_idx, 5);
        tick();
        wakeup_valid = 1'b1; wakeup_tag = 7'd20;
        #1;
`ifdef ISSUE_WAKEUP_BYPASS_EN
        check("wake_same_cycle", issue_valid, 1);
`else
        check("wake_same_cycle", issue_valid, 0);
`endif
        tick();
        wakeup_valid = 1'b0;
`ifdef ISSUE_WAKEUP_BYPASS_EN
        check("wake_next_cycle", issue_valid, 0);
`else
        check("wake_next_cycle", issue_valid, 1);
        check("wake_next_rob", issue_rob_idx, 4);
`endif
        tick();
        check("wake_empty", empty, 1);

        // fill all 8 slots, drop a 9th, then drain oldest first
        issue_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_issue(5'(i), 7'(60 + i), 1, 2, 32'hA000_0000 + i);
            dispatch(5'(i), 7'(60 + i), 1, 1, 2, 1, 32'hA000_0000 + i);
        end
        check("full_flag", full, 1);
        check("full_dispatch_ready", dispatch_ready, 0);
        check("full_occupancy", occupancy, 8);
        dispatch(9, 99, 1, 1, 2, 1, 32'hDEAD_0009);
        check("full_drop_occupancy", occupancy, 8);
        check("full_pick_oldest", issue_rob_idx, 0);
        issue_ready = 1'b1;
        for (int n = 0; n < 20 && !empty; n++) tick();
        check("drain_empty", empty, 1);
        check("drain_queue", q.size(), 0);

        // rs2 woken in the dispatch cycle is captured as ready
        expect_issue(7, 43, 30, 33, 32'hCCCC_0007);
        wakeup_valid = 1'b1; wakeup_tag = 7'd33;
        dispatch(7, 43, 30, 1, 33, 0, 32'hCCCC_0007);
        wakeup_valid = 1'b0;
        check("dispwake_valid", issue_valid, 1);
        check("dispwake_rob", issue_rob_idx, 7);
        tick();
        check("dispwake_empty", empty, 1);

        // stall stability, single handshake, then dispatch+issue in one cycle
        issue_ready = 1'b0;
        expect_issue(12, 50, 3, 4, 32'h0000_0012);
        expect_issue(13, 51, 5, 6, 32'h0000_0013);
        expect_issue(14, 52, 7, 8, 32'h0000_0014);
        dispatch(12, 50, 3, 1, 4, 1, 32'h0000_0012);
        dispatch(13, 51, 5, 1, 6, 1, 32'h0000_0013);
        for (int n = 0; n < 3; n++) begin
            check("stall_valid", issue_valid, 1);
            check("stall_rob", issue_rob_idx, 12);
            check("stall_rd", issue_rd, 50);
            tick();
        end
        issue_ready = 1'b1;
        tick();
        check("hs_occupancy", occupancy, 1);
        check("hs_next_rob", issue_rob_idx, 13);
        dispatch(14, 52, 7, 1, 8, 1, 32'h0000_0014);
        check("both_occupancy", occupancy, 1);
        check("both_rob", issue_rob_idx, 14);
        tick();
        check("both_empty", empty, 1);

        // flush overrides a simultaneous dispatch
        issue_ready = 1'b0;
        for (int i = 0; i < 5; i++) dispatch(5'(20 + i), 7'(70 + i), 9, 1, 9, 1, 32'hF000_0000 + i);
        check("preflush_occupancy", occupancy, 5);
        check("preflush_valid", issue_valid, 1);
        flush = 1'b1;
        dispatch(25, 75, 9, 1, 9, 1, 32'hF000_0005);
        flush = 1'b0;
        check("flush_occupancy", occupancy, 0);
        check("flush_empty", empty, 1);
        check("flush_issue_valid", issue_valid, 0);
        check("flush_dispatch_ready", dispatch_ready, 1);
        issue_ready = 1'b1;
        tick(); tick();
        check("final_queue", q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Reservation-station issue scheduler sitting between dispatch (decode_DS / reg_map_table / reorder_buffer) and the execute unit of the out-of-order pipeline. It buffers renamed instructions and tracks operand readiness by snooping physical-register wakeup broadcasts. Each cycle it selects the oldest instruction with both operands ready and presents it to execute with a valid/ready handshake. Its dispatch_ready output is the "station used/full" input decode_DS uses to stall fetch.

Parameters:
ENTRIES, 8, number of station slots (power of 2, >=2)
REG_FILE_ADDR_WIDTH, 7, physical register tag width
ROB_ADDR_WIDTH, 5, reorder buffer index width
PAYLOAD_WIDTH, 32, opaque payload width (instruction word)

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
flush  in  1  rollback: discard all entries
dispatch_valid  in  1  dispatch offers an entry
dispatch_ready  out  1  slot available (== !full)
dispatch_rob_idx  in  ROB_ADDR_WIDTH  ROB index of instruction
dispatch_rd  in  REG_FILE_ADDR_WIDTH  destination phys reg
dispatch_rs1  in  REG_FILE_ADDR_WIDTH  source 1 phys reg
dispatch_rs1_ready  in  1  source 1 already available
dispatch_rs2  in  REG_FILE_ADDR_WIDTH  source 2 phys reg
dispatch_rs2_ready  in  1  source 2 already available
dispatch_payload  in  PAYLOAD_WIDTH  instruction word
wakeup_valid  in  1  phys reg written this cycle
wakeup_tag  in  REG_FILE_ADDR_WIDTH  phys reg being written
issue_valid  out  1  selected entry valid
issue_ready  in  1  execute accepts
issue_rob_idx / issue_rd / issue_rs1 / issue_rs2 / issue_payload  out  as dispatch  selected entry fields
occupancy  out  $clog2(ENTRIES)+1  valid entry count
empty  out  1  occupancy == 0
full  out  1  occupancy == ENTRIES

Behaviour:
- One clock, synchronous active-high reset: all entry valid bits 0, age counters 0, occupancy 0. Outputs after reset: issue_valid 0, dispatch_ready 1, empty 1, full 0, issue_* fields 0.
- Entry state: valid, rob_idx, rd, rs1, rs1_rdy, rs2, rs2_rdy, payload, age (8-bit saturating).
- Dispatch: dispatch_valid && dispatch_ready at edge -> lowest-index free slot written, age=0. Ready bit stored = dispatch_rsX_ready | (wakeup_valid && wakeup_tag==dispatch_rsX).
- Age: on each accepted dispatch, every other valid entry's age increments, saturating at 255.
- Wakeup: each edge with wakeup_valid, every valid entry with rsX==wakeup_tag sets rsX_rdy. Both sources may match in the same cycle.
- Select (combinational from registered state): eligible = valid && rs1_rdy && rs2_rdy. Pick max age; ties broken by lowest index. issue_valid = any eligible; issue_* = fields of pick, 0 when none.
- Issue: issue_valid && issue_ready at edge -> picked slot cleared. Pick must remain stable while issue_valid && !issue_ready unless an older entry becomes eligible; execute samples only on handshake.
- Latency: entry dispatched ready at edge k -> issue_valid in cycle k+1 (station otherwise idle).
- Full: dispatch_ready = !full, even when an issue frees a slot the same cycle (no freed-slot bypass). Dispatch while full is ignored.
- Simultaneous dispatch+issue: occupancy unchanged; the issued slot is never the dispatch target.
- flush: at edge, all valid bits cleared; it overrides dispatch, issue and wakeup in that cycle. Outputs return to reset values next cycle. Reset mid-operation behaves the same.
- occupancy = +1 dispatch, -1 issue, net 0 both.

Optional Feature:
ISSUE_WAKEUP_BYPASS_EN: when defined, eligibility also counts a source as ready when wakeup_valid && wakeup_tag matches this cycle. An entry whose last operand is woken in cycle c may therefore issue in cycle c. Not defined: eligibility uses registered ready bits only, and that entry issues no earlier than c+1.

Test Plan:
- Reset, then dispatch {rob 3, rd 40, rs1 10 rdy, rs2 11 rdy} with issue_ready=1 -> issue_valid=1 next cycle, issue_rob_idx=3, issue_rd=40; empty=1 after.
- Dispatch A (rs1=20 not ready), then B (ready) -> B issues first; drive wakeup tag 20 -> A issues next cycle (same cycle if ISSUE_WAKEUP_BYPASS_EN).
- Dispatch 8 ready entries, issue_ready=0 -> full=1, dispatch_ready=0, 9th dispatch dropped; release -> issue order rob 0..7 (oldest first).
- Dispatch with rs2=33 not ready while wakeup tag 33 in same cycle -> entry stored ready, issues next cycle.
- Hold issue_ready=0 with issue_valid=1 for 3 cycles -> issue_* stable; then handshake -> occupancy decrements by 1.
- 5 entries valid, assert flush together with dispatch_valid -> next cycle occupancy=0, empty=1, issue_valid=0.
